// File: rtl/idma_cmd_arbiter.sv
// idma_cmd_arbiter
// Round-robin arbiter that shares the DMA engine's command/status stream pair
// between NREQ requesters. One 3-word command packet is forwarded at a time.
// The grant is held until the engine's 1-beat status has been handed back to
// the requester that issued the command.
//
// Build option: define IDMA_ARB_TIMEOUT_EN to enable the status watchdog.
// On expiry it synthesises an error status and discards the engine's late reply.

module idma_cmd_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [32*NREQ-1:0]   req_s_tdata,
    input  logic [NREQ-1:0]      req_s_tvalid,
    input  logic [NREQ-1:0]      req_s_tlast,
    output logic [NREQ-1:0]      req_s_tready,
    output logic [31:0]          cmd_m_tdata,
    output logic                 cmd_m_tvalid,
    output logic                 cmd_m_tlast,
    input  logic                 cmd_m_tready,
    input  logic [31:0]          stat_s_tdata,
    input  logic                 stat_s_tvalid,
    output logic                 stat_s_tready,
    output logic [31:0]          stat_m_tdata,
    output logic [NREQ-1:0]      stat_m_tvalid,
    input  logic [NREQ-1:0]      stat_m_tready,
    output logic                 busy
);

    // state | meaning
    // ------+--------------------------------------------------------------
    // IDLE  | no command in flight; pick next requester round-robin
    // FWD   | pass granted requester's command beats through to the engine
    // WAIT  | command sent; wait for the engine's status beat
    // DLVR  | hold registered status on stat_m until the owner accepts it

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 65536) begin : g_param_check
        $error("idma_cmd_arbiter: NREQ must be 2..8 and TIMEOUT 2..65536");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DLVR = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   rr_ptr_q;
    logic [31:0]     stat_q;

    logic [GW-1:0]   arb_sel;
    logic            arb_found;
    logic [GW-1:0]   arb_cand;
    int              arb_idx;
    logic            arb_take;
    logic            stat_load;
    logic [31:0]     stat_load_data;
    logic            stat_hs;
    logic            cmd_hs;
    logic            stat_discard;
    logic            timeout_hit;
    logic [31:0]     timeout_stat;

    logic [31:0]     req_word [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign req_word[g] = req_s_tdata[32*g +: 32];
    end

    // Lane mux: only the granted requester reaches the engine, and only in FWD.
    assign cmd_m_tvalid = (state_q == ST_FWD) && req_s_tvalid[grant_q];
    assign cmd_m_tlast  = (state_q == ST_FWD) && req_s_tlast[grant_q];
    assign cmd_m_tdata  = (state_q == ST_FWD) ? req_word[grant_q] : 32'h0;
    assign req_s_tready = ((state_q == ST_FWD) && cmd_m_tready) ? (NREQ'(1) << grant_q) : '0;

    assign stat_m_tdata  = stat_q;
    assign stat_m_tvalid = (state_q == ST_DLVR) ? (NREQ'(1) << grant_q) : '0;
    assign busy          = (state_q != ST_IDLE);

    assign cmd_hs  = cmd_m_tvalid && cmd_m_tready;
    assign stat_hs = stat_s_tvalid && stat_s_tready;

`ifdef IDMA_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic        drop_q;
    logic [31:0] first_word_q;
    logic        first_pend_q;

    // A late reply after a timeout is swallowed, whatever state we are in.
    assign stat_s_tready = (state_q == ST_WAIT) || drop_q;
    assign stat_discard  = drop_q && stat_hs;
    assign timeout_hit   = (state_q == ST_WAIT) && !stat_hs && (to_cnt_q == 16'(TIMEOUT - 1));
    assign timeout_stat  = {first_word_q[31], 3'b111, first_word_q[27:16], first_word_q[15:0]};

    // Watchdog counter, drop flag and capture of the command's first word.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            to_cnt_q     <= 16'h0;
            drop_q       <= 1'b0;
            first_word_q <= 32'h0;
            first_pend_q <= 1'b0;
        end else begin
            if (state_q == ST_FWD && state_d == ST_WAIT) begin
                to_cnt_q <= 16'h0;
            end else if (state_q == ST_WAIT) begin
                to_cnt_q <= to_cnt_q + 16'h1;
            end

            if (timeout_hit) begin
                drop_q <= 1'b1;
            end else if (stat_discard) begin
                drop_q <= 1'b0;
            end

            if (arb_take) begin
                first_pend_q <= 1'b1;
            end else if (cmd_hs && first_pend_q) begin
                first_word_q <= cmd_m_tdata;
                first_pend_q <= 1'b0;
            end
        end
    end
`else
    assign stat_s_tready = (state_q == ST_WAIT);
    assign stat_discard  = 1'b0;
    assign timeout_hit   = 1'b0;
    assign timeout_stat  = 32'h0;
`endif

    // Round-robin search: first valid requester after the last one served.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = rr_ptr_q;
        arb_idx   = 0;
        arb_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            arb_idx  = (int'(rr_ptr_q) + k) % NREQ;
            arb_cand = GW'(arb_idx);
            if (!arb_found && req_s_tvalid[arb_cand]) begin
                arb_sel   = arb_cand;
                arb_found = 1'b1;
            end
        end
    end

    // Next-state logic and status-register load control.
    always_comb begin
        state_d        = state_q;
        arb_take       = 1'b0;
        stat_load      = 1'b0;
        stat_load_data = stat_s_tdata;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    arb_take = 1'b1;
                    state_d  = ST_FWD;
                end
            end
            ST_FWD: begin
                if (cmd_hs && cmd_m_tlast) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stat_hs && !stat_discard) begin
                    stat_load = 1'b1;
                    state_d   = ST_DLVR;
                end else if (timeout_hit) begin
                    stat_load      = 1'b1;
                    stat_load_data = timeout_stat;
                    state_d        = ST_DLVR;
                end
            end
            ST_DLVR: begin
                if (stat_m_tready[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, grant, round-robin pointer and delivered status registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= GW'(NREQ - 1);
            stat_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (arb_take) begin
                grant_q  <= arb_sel;
                rr_ptr_q <= arb_sel;
            end
            if (stat_load) begin
                stat_q <= stat_load_data;
            end
        end
    end

endmodule
